// File: rtl/pic_pkg.sv
// Shared encodings for the 8259A-subset interrupt controller: init-sequence
// states, OCW2 command codes and command-word bit positions.
package pic_pkg;

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } init_state_t;

    localparam logic [2:0] EOI_NS = 3'b001;
    localparam logic [2:0] EOI_SP = 3'b011;

    localparam int ICW1_BIT = 4;
    localparam int OCW3_BIT = 3;

endpackage

// File: rtl/pic_ctrl_if.sv
// CPU-side bus of the interrupt controller: I/O port access plus the
// interrupt-acknowledge / vector handshake.
interface pic_ctrl_if;
    logic       iIoA0;
    logic       iIoWr;
    logic       iIoRd;
    logic [7:0] iIoData;
    logic [7:0] oIoData;
    logic       oIoSel;
    logic       iIntAck;
    logic       oInt;
    logic       oSel;
    logic [7:0] oData;

    modport slave (
        input  iIoA0, iIoWr, iIoRd, iIoData, iIntAck,
        output oIoData, oIoSel, oInt, oSel, oData
    );

    modport master (
        output iIoA0, iIoWr, iIoRd, iIoData, iIntAck,
        input  oIoData, oIoSel, oInt, oSel, oData
    );
endinterface

// File: rtl/pic_prio8.sv
// Combinational lowest-set-bit encoder: bit 0 is the highest priority.
module pic_prio8 (
    input  logic [7:0] i_vec,
    output logic [2:0] o_idx,
    output logic       o_vld
);
    always_comb begin
        o_idx = 3'd0;
        o_vld = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 3'(i);
                o_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/pic_ctrl.sv
// 8-input programmable interrupt controller: IRR/ISR/IMR, fixed priority,
// ICW1/2/4 init sequence, OCW1/2/3 commands and the INTA vector cycle.
module pic_ctrl
    import pic_pkg::*;
#(
    parameter logic [7:0] VEC_BASE_RST = 8'h08,
    parameter logic [7:0] IMR_RST      = 8'h00
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic [7:0] iIrq,
    pic_ctrl_if.slave  bus
);
    init_state_t r_state, w_state_nxt;
    logic [7:0]  r_irr, r_isr, r_imr, r_prev;
    logic [4:0]  r_base;
    logic        r_aeoi, r_rdsel, r_sngl, r_ic4;
    logic        r_int, r_sel, r_iosel;
    logic [7:0]  r_data, r_iodata;

    logic [7:0]  w_req, w_rise, w_below, w_eoi_clr, w_ack_bit;
    logic [2:0]  w_req_idx, w_isr_idx;
    logic        w_req_vld, w_isr_vld, w_ack_hit;
    logic [3:0]  w_isr_top;
    logic        w_icw1, w_ocw1, w_ocw2, w_ocw3, w_icw2_ld, w_icw4_ld;
    logic        w_ready_wr;

    pic_prio8 u_prio_req (.i_vec(w_req), .o_idx(w_req_idx), .o_vld(w_req_vld));
    pic_prio8 u_prio_isr (.i_vec(r_isr), .o_idx(w_isr_idx), .o_vld(w_isr_vld));

    assign w_req     = r_irr & ~r_imr;
    assign w_rise    = iIrq & ~r_prev;
    assign w_isr_top = w_isr_vld ? {1'b0, w_isr_idx} : 4'd8;
    assign w_ack_hit = bus.iIntAck & w_req_vld;
    assign w_ack_bit = 8'b1 << w_req_idx;

    // Only requests strictly above the highest in-service level may interrupt.
    always_comb begin
        for (int i = 0; i < 8; i++) w_below[i] = (4'(i) < w_isr_top);
    end

    assign w_icw1     = bus.iIoWr & ~bus.iIoA0 & bus.iIoData[ICW1_BIT];
    assign w_ready_wr = bus.iIoWr & (r_state == READY);
    assign w_ocw1     = w_ready_wr & bus.iIoA0;
    assign w_ocw2     = w_ready_wr & ~bus.iIoA0 & ~bus.iIoData[ICW1_BIT] & ~bus.iIoData[OCW3_BIT];
    assign w_ocw3     = w_ready_wr & ~bus.iIoA0 & ~bus.iIoData[ICW1_BIT] &  bus.iIoData[OCW3_BIT];

    always_comb begin
        w_eoi_clr = 8'h00;
        if (w_ocw2) begin
            case (bus.iIoData[7:5])
                EOI_NS:  if (w_isr_vld) w_eoi_clr[w_isr_idx] = 1'b1;
                EOI_SP:  w_eoi_clr[bus.iIoData[2:0]] = 1'b1;
                default: w_eoi_clr = 8'h00;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_icw2_ld   = 1'b0;
        w_icw4_ld   = 1'b0;
        if (w_icw1) begin
            w_state_nxt = WAIT_ICW2;
        end else if (bus.iIoWr && bus.iIoA0) begin
            case (r_state)
                WAIT_ICW2: begin
                    w_icw2_ld   = 1'b1;
                    w_state_nxt = !r_sngl ? WAIT_ICW3 : (r_ic4 ? WAIT_ICW4 : READY);
                end
                WAIT_ICW3: w_state_nxt = r_ic4 ? WAIT_ICW4 : READY;
                WAIT_ICW4: begin
                    w_icw4_ld   = 1'b1;
                    w_state_nxt = READY;
                end
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) r_state <= READY;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_irr    <= 8'h00;
            r_isr    <= 8'h00;
            r_imr    <= IMR_RST;
            r_prev   <= 8'h00;
            r_base   <= VEC_BASE_RST[7:3];
            r_aeoi   <= 1'b0;
            r_rdsel  <= 1'b0;
            r_sngl   <= 1'b0;
            r_ic4    <= 1'b0;
            r_int    <= 1'b0;
            r_sel    <= 1'b0;
            r_data   <= 8'h00;
            r_iosel  <= 1'b0;
            r_iodata <= 8'h00;
        end else begin
            r_prev  <= iIrq;
            r_int   <= |(w_req & w_below);
            r_sel   <= bus.iIntAck;
            r_data  <= !bus.iIntAck ? 8'h00 :
                       w_req_vld    ? {r_base, w_req_idx} : {r_base, 3'b111};
            // Read data is taken from the pre-update registers.
            r_iosel  <= bus.iIoRd;
            r_iodata <= !bus.iIoRd ? 8'h00 :
                        bus.iIoA0  ? r_imr : (r_rdsel ? r_isr : r_irr);
            if (w_icw1) begin
                r_irr   <= 8'h00;
                r_isr   <= 8'h00;
                r_imr   <= 8'h00;
                r_rdsel <= 1'b0;
                r_sngl  <= bus.iIoData[1];
                r_ic4   <= bus.iIoData[0];
            end else begin
                r_irr <= (r_irr & ~(w_ack_hit ? w_ack_bit : 8'h00)) | w_rise;
                r_isr <= (r_isr & ~w_eoi_clr) | ((w_ack_hit && !r_aeoi) ? w_ack_bit : 8'h00);
                if (w_ocw1) r_imr <= bus.iIoData;
                if (w_ocw3 && bus.iIoData[1]) r_rdsel <= bus.iIoData[0];
            end
            if (w_icw2_ld) r_base <= bus.iIoData[7:3];
            if (w_icw4_ld) r_aeoi <= bus.iIoData[1];
        end
    end

    assign bus.oInt    = r_int;
    assign bus.oSel    = r_sel;
    assign bus.oData   = r_data;
    assign bus.oIoSel  = r_iosel;
    assign bus.oIoData = r_iodata;
endmodule

// File: tb/tb_pic_ctrl.sv
// Directed bench for pic_ctrl: expected vectors and read data are queued when
// the request is issued and compared when the controller returns them.
module tb_pic_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] q_rd[$];
    logic [7:0] q_vec[$];

    pic_ctrl_if bus ();

    pic_ctrl #(.VEC_BASE_RST(8'h08), .IMR_RST(8'h00)) dut (
        .iClk (clk),
        .iRstN(rst_n),
        .iIrq (irq),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic a0, input logic [7:0] d);
        bus.iIoA0 = a0; bus.iIoData = d; bus.iIoWr = 1'b1;
        tick();
        bus.iIoWr = 1'b0;
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (bus.oIoSel !== 1'b1 && n < 4) begin tick(); n++; end
        checks++;
        assert (bus.oIoSel === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=no_oIoSel expected=oIoSel", tag);
        end
        if (bus.oIoSel === 1'b1) chk(tag, bus.oIoData, q_rd.pop_front());
        else void'(q_rd.pop_front());
    endtask

    task automatic rd(input logic a0, input logic [7:0] exp, input string tag);
        q_rd.push_back(exp);
        bus.iIoA0 = a0; bus.iIoRd = 1'b1;
        tick();
        bus.iIoRd = 1'b0;
        wait_rd(tag);
    endtask

    task automatic ack(input logic [7:0] exp, input string tag);
        int n = 0;
        q_vec.push_back(exp);
        bus.iIntAck = 1'b1;
        tick();
        bus.iIntAck = 1'b0;
        while (bus.oSel !== 1'b1 && n < 4) begin tick(); n++; end
        checks++;
        assert (bus.oSel === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=no_oSel expected=oSel", tag);
        end
        if (bus.oSel === 1'b1) chk(tag, bus.oData, q_vec.pop_front());
        else void'(q_vec.pop_front());
        tick();
        chk({tag, "_oSel_1cyc"}, {7'd0, bus.oSel}, 8'h00);
    endtask

    task automatic pulse(input logic [7:0] lines);
        irq = lines;
        tick();
        irq = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; irq = 8'h00;
        bus.iIoA0 = 1'b0; bus.iIoWr = 1'b0; bus.iIoRd = 1'b0;
        bus.iIoData = 8'h00; bus.iIntAck = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_oInt",    {7'd0, bus.oInt},   8'h00);
        chk("rst_oSel",    {7'd0, bus.oSel},   8'h00);
        chk("rst_oData",   bus.oData,          8'h00);
        chk("rst_oIoSel",  {7'd0, bus.oIoSel}, 8'h00);
        chk("rst_oIoData", bus.oIoData,        8'h00);
        rd(1'b0, 8'h00, "rst_irr");
        rd(1'b1, 8'h00, "rst_imr");

        // Single IRQ0 at reset defaults
        pulse(8'h01);
        chk("irq0_int_lat1", {7'd0, bus.oInt}, 8'h00);
        tick();
        chk("irq0_int_lat2", {7'd0, bus.oInt}, 8'h01);
        ack(8'h08, "irq0_vec");
        chk("irq0_int_after_ack", {7'd0, bus.oInt}, 8'h00);
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h01, "irq0_isr");
        wr(1'b0, 8'h20);
        rd(1'b0, 8'h00, "irq0_isr_eoi");

        // Init sequence with ICW4, mask IRQ1 only open
        wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h09);
        wr(1'b1, 8'hFD);
        pulse(8'h03);
        tick();
        chk("init_int", {7'd0, bus.oInt}, 8'h01);
        ack(8'h09, "init_vec");
        rd(1'b1, 8'hFD, "init_imr");
        wr(1'b0, 8'h20);
        rd(1'b0, 8'h01, "init_irr_masked");

        // Nesting: IRQ3 in service blocks IRQ5, not IRQ1
        wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h09);
        pulse(8'h08);
        tick();
        ack(8'h0B, "nest_irq3_vec");
        pulse(8'h20);
        tick(); tick();
        chk("nest_irq5_blocked", {7'd0, bus.oInt}, 8'h00);
        pulse(8'h02);
        tick();
        chk("nest_irq1_int", {7'd0, bus.oInt}, 8'h01);
        ack(8'h09, "nest_irq1_vec");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h0A, "nest_isr");
        wr(1'b0, 8'h20);
        rd(1'b0, 8'h08, "nest_isr_ns_eoi");
        wr(1'b0, 8'h63);
        rd(1'b0, 8'h00, "nest_isr_sp_eoi");

        // OCW3 read select
        wr(1'b0, 8'h0A);
        rd(1'b0, 8'h20, "ocw3_irr");
        wr(1'b0, 8'h08);
        rd(1'b0, 8'h20, "ocw3_keep_irr");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h00, "ocw3_isr");
        wr(1'b0, 8'h08);
        rd(1'b0, 8'h00, "ocw3_keep_isr");
        ack(8'h0D, "irq5_vec");
        wr(1'b0, 8'h20);

        // Spurious acknowledge with only masked requests pending
        wr(1'b1, 8'hFF);
        pulse(8'h04);
        tick();
        ack(8'h0F, "spurious_vec");
        wr(1'b0, 8'h0A);
        rd(1'b0, 8'h04, "spurious_irr");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h00, "spurious_isr");

        // Reset in the middle of initialisation
        wr(1'b0, 8'h13);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        wr(1'b1, 8'h55);
        rd(1'b1, 8'h55, "midinit_imr");
        pulse(8'h02);
        tick();
        ack(8'h09, "midinit_base");

        // Automatic EOI
        wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h0B);
        pulse(8'h48);
        tick();
        chk("aeoi_int", {7'd0, bus.oInt}, 8'h01);
        ack(8'h0B, "aeoi_vec3");
        wr(1'b0, 8'h0B);
        rd(1'b0, 8'h00, "aeoi_isr");
        chk("aeoi_int_next", {7'd0, bus.oInt}, 8'h01);
        ack(8'h0E, "aeoi_vec6");
        rd(1'b0, 8'h00, "aeoi_isr_after");

        // Read and write in the same cycle returns the old IMR
        q_rd.push_back(8'h00);
        bus.iIoA0 = 1'b1; bus.iIoData = 8'h33; bus.iIoWr = 1'b1; bus.iIoRd = 1'b1;
        tick();
        bus.iIoWr = 1'b0; bus.iIoRd = 1'b0;
        wait_rd("rdwr_old_imr");
        rd(1'b1, 8'h33, "rdwr_new_imr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pic_ctrl.md
Name: pic_ctrl

Overview:
8-input, 8259A-subset programmable interrupt controller that replaces the fixed two-line PIC in the chipset. It owns the IRR, ISR and IMR registers and sequences the CPU interrupt-acknowledge cycle. It decodes the ICW1/ICW2/ICW4 initialisation sequence and OCW1/OCW2/OCW3 commands from the I/O bus (ports 0x20/0x21).
It sits between the timer, keyboard and other IRQ sources, the CPU bus interface (INTA, I/O strobes) and the bus data mux.

Parameters:
VEC_BASE_RST, 8'h08, vector base (ICW2 value) in effect after reset.
IMR_RST, 8'h00, mask register value after reset.

Ports:
iClk  in  1  system clock
iRstN  in  1  reset, asynchronous, active-low
iIrq  in  8  interrupt request lines, bit 0 highest priority, rising-edge sensitive
iIoA0  in  1  port select: 0 = 0x20, 1 = 0x21
iIoWr  in  1  one-cycle I/O write strobe, PIC decoded
iIoRd  in  1  one-cycle I/O read strobe, PIC decoded
iIoData  in  8  I/O write data
oIoData  out  8  I/O read data
oIoSel  out  1  oIoData valid / drive bus
iIntAck  in  1  one-cycle CPU interrupt-acknowledge pulse
oInt  out  1  interrupt request to CPU
oSel  out  1  oData valid / drive bus
oData  out  8  interrupt vector

Behaviour:
- Reset (iRstN low, async): IRR=0, ISR=0, IMR=IMR_RST, base=VEC_BASE_RST, aeoi=0, rdsel=IRR, init state READY, edge history=0. Outputs: oInt=0, oSel=0, oData=0, oIoSel=0, oIoData=0. Reset mid-init aborts to READY.
- Edge detect: prev<=iIrq each cycle. rise=iIrq&~prev sets the IRR bit.
- Priority: fixed, bit 0 highest. req = IRR & ~IMR. isr_top = lowest set ISR index (8 if none). oInt (registered) = 1 when any req bit has index < isr_top.
- Ack: on iIntAck, n = lowest set bit of req. Next cycle: ISR[n]=1 (unless aeoi), IRR[n]=0, oData=base[7:3]|n, oSel=1 for exactly one cycle. If req=0, oData=base|7 (spurious) and IRR/ISR are unchanged.
- Init FSM states: READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
  - Write A0=0 with D4=1 (ICW1), from any state: clears IRR, ISR, IMR; rdsel=IRR; latches sngl=D1 and ic4=D0; goes to WAIT_ICW2.
  - WAIT_ICW2 + write A0=1: base=D[7:3]. Next state is WAIT_ICW3 if !sngl, else WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW3 + write A0=1: data ignored. Next state is WAIT_ICW4 if ic4, else READY.
  - WAIT_ICW4 + write A0=1: aeoi=D1, other bits ignored; go to READY.
  - A write with A0=0 and D4=0 in a WAIT state is ignored, FSM unchanged.
- READY + write A0=1 (OCW1): IMR=D.
- READY + write A0=0, D4=0, D3=0 (OCW2), decoded on D[7:5]:
  - 001 non-specific EOI: clear ISR[isr_top].
  - 011 specific EOI: clear ISR[D[2:0]].
  - Other codes: no-op.
- READY + write A0=0, D4=0, D3=1 (OCW3): if D1=1, rdsel=D0 (0=IRR, 1=ISR). Other bits ignored.
- Read: on iIoRd, next cycle oIoSel=1 for one cycle. oIoData = A0 ? IMR : (rdsel ? ISR : IRR). Reads have no side effects.
- Simultaneous events:
  - ISR_next = (ISR & ~eoi_clr) | ack_set.
  - IRR_next = (IRR & ~ack_clr) | rise. Set wins on the same bit.
  - An IMR write takes effect from the next cycle. An ack in the same cycle uses the old IMR.
  - iIoWr and iIoRd in the same cycle: both are serviced; the read returns pre-write values.
- Latency: irq edge -> oInt high takes 2 cycles (edge reg, IRR). oInt is recomputed every cycle.

Decomposition:
- pic_pkg holds:
  - init-state encoding (READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4);
  - OCW2 command codes (EOI_NS=3'b001, EOI_SP=3'b011);
  - the ICW1_BIT=4 and OCW3_BIT=3 bit positions.
- One sub-module, pic_prio8: combinational lowest-set-bit encoder with an 8-bit input, giving a 3-bit index and a valid flag. It is instantiated twice, for req and for ISR.

Test Plan:
- Reset, then pulse iIrq[0] once, then iIntAck -> oInt=1 two cycles after the edge. One cycle after ack: oSel=1 and oData=8'h08. ISR reads 8'h01, and oInt=0 until EOI.
- Init with ICW1=8'h13, ICW2=8'h08, ICW4=8'h09, then OCW1=8'hFD. Edges on iIrq[0] and iIrq[1] -> oInt=1. Ack gives oData=8'h09. Reading 0x21 returns 8'hFD.
- With IRQ3 in service, raise IRQ5 -> oInt stays 0. Raise IRQ1 -> oInt=1, ack gives 8'h09 and ISR=8'h0A. Write 8'h20 -> ISR=8'h08. Write 8'h63 -> ISR=8'h00.
- OCW3=8'h0B, then read 0x20 -> returns ISR. OCW3=8'h0A -> returns IRR. OCW3=8'h08 -> rdsel unchanged.
- iIntAck with req=0 and base 8'h08 -> oData=8'h0F; IRR and ISR unchanged.
- Assert iRstN low after ICW1 and before ICW2 -> FSM is READY and base=8'h08. A following write of 8'h55 to 0x21 sets IMR=8'h55.
- ICW4 with D1=1 (aeoi) -> ack leaves ISR=0, so lower-priority IRQs are serviced immediately after.
